matrix_frame_receiver: RTL and testbench
========================================

// Module: matrix_frame_receiver
// PURPOSE
//  Receiving end of the LED-matrix serial link (DIN/CS/LED_CLK, 16-bit addr+data words, MAX7219 register map).
//  Oversamples the link on the system clock, reassembles daisy-chained words and keeps a shadow register file per device.
//  Presents the resulting pixel image for the bench scoreboard and for on-screen mirroring of the snake grid.
// PARAMETERS
//  N_DEV    1  number of daisy-chained 8x8 devices modelled (1..4)
// PORTS
//  clk          in   1          system clock, single clock domain; must be >= 4x LED_CLK frequency
//  reset_n      in   1          asynchronous, active-low reset
//  DIN          in   1          serial data, MSB first, valid on LED_CLK rising edge
//  CS           in   1          chip select/load; low while shifting, rising edge latches words
//  LED_CLK      in   1          serial clock
//  rows         out  N_DEV*64   raw digit regs: rows[d*64 + r*8 +: 8] = device d, addr r+1
//  pixels       out  N_DEV*64   displayed image, same packing as rows (see BEHAVIOUR)
//  intensity    out  N_DEV*4    intensity reg (addr 0x0A) per device
//  shutdown_n   out  N_DEV      1 = normal operation (addr 0x0C bit0)
//  upd          out  N_DEV      1-cycle pulse: device d register file written this cycle
//  frame_err    out  1          1-cycle pulse: load with bit count != 16*N_DEV
// BEHAVIOUR
//  - Sync: DIN, CS, LED_CLK each pass a 2-FF synchronizer; edges detected on synchronized copies.
//  - Shift reg sr[16*N_DEV-1:0]: on LED_CLK rise while CS low, sr <= {sr[16*N_DEV-2:0], DIN}.
//    Device d's word = sr[16*d +: 16]; d=0 is the word shifted LAST (nearest device).
//  - bit_cnt: cleared on CS falling edge, +1 per sampled bit, saturates at 16*N_DEV+1.
//  - FSM: IDLE (CS high) -> SHIFT on CS fall; SHIFT -> LATCH on CS rise; LATCH -> IDLE after 1 cycle.
//    LED_CLK edges in IDLE are ignored (no shift).
//  - LATCH: if bit_cnt >= 16, every device with 16*(d+1) <= bit_cnt decodes its word; devices beyond the
//    received count keep their state. frame_err pulses in LATCH if bit_cnt != 16*N_DEV (incl. < 16).
//  - Decode, addr = word[11:8] (word[15:12] ignored), data = word[7:0]:
//    0x0 no-op; 0x1-0x8 rows row addr-1 <= data; 0x9 decode_mode <= data; 0xA intensity <= data[3:0];
//    0xB scan_limit <= data[2:0]; 0xC shutdown_n <= data[0]; 0xF disp_test <= data[0]; 0xD/0xE ignored.
//    upd[d] pulses only for addresses 0x1-0xC and 0xF.
//  - Latency: CS rising at pin -> registers/upd updated on 4th clk edge (2 sync + edge + LATCH).
//  - pixels (registered, same cycle as register update): disp_test -> all 1s;
//    else shutdown_n==0 -> all 0s; else row r = rows[r] if r <= scan_limit else 0.
//    decode_mode is stored only (no BCD decode); affects nothing else.
//  - CS rise coincident with an LED_CLK rise: the bit is NOT shifted (load wins).
//  - CS falling during LATCH: LATCH completes, then SHIFT entered with bit_cnt = 0.
//  - Reset values: sr=0, bit_cnt=0, FSM=IDLE, rows=0, decode_mode=0, intensity=0, scan_limit=0,
//    shutdown_n=0, disp_test=0, pixels=0, upd=0, frame_err=0; sync FFs reset to CS=1, LED_CLK=0, DIN=0.
//  - reset_n asserted mid-word: partial word discarded, no register written, no upd/frame_err pulse.
// TESTING
//  1 reset_n low then high, idle link -> rows=0, pixels=0, shutdown_n=0, intensity=0, no pulses.
//  2 N_DEV=1: send 0x0C01, 0x0B07, 0x03A5 -> shutdown_n=1, rows row2=0xA5, pixels row2=0xA5, 3 upd pulses.
//  3 N_DEV=2: one load of 32 bits 0x0A03_0A0C -> intensity dev1=3, dev0=0xC, upd=2'b11, no frame_err.
//  4 N_DEV=1: load after 12 bits -> frame_err pulse, no upd, all registers unchanged.
//  5 scan_limit=2, rows 1..8 = 0xFF, then 0x0F01 -> pixels all 1s; 0x0F00 -> rows 0-2 = 0xFF, rows 3-7 = 0.
//  6 reset_n pulsed low after 9 bits, then full 0x0155 word -> only 0x0155 applied: row0=0x55, one upd.

Source files
------------

// File: rtl/matrix_frame_receiver_if.sv
// matrix_frame_receiver_if
//   Three-wire LED-matrix serial link (MAX7219 style).
//   Signals:
//     DIN      serial data, MSB first, sampled on LED_CLK rising edge
//     CS       chip select / load; low while shifting, rising edge latches
//     LED_CLK  serial clock
//   Modports: master drives the link (controller / bench), slave receives it.
interface matrix_frame_receiver_if;
  logic DIN;
  logic CS;
  logic LED_CLK;

  modport master (output DIN, output CS, output LED_CLK);
  modport slave  (input  DIN, input  CS, input  LED_CLK);
endinterface

// File: rtl/matrix_frame_receiver.sv
// matrix_frame_receiver
//   Receiving end of the LED-matrix serial link. The link is oversampled on
//   clk, daisy-chained 16-bit words are reassembled in one shift register and
//   each modelled device keeps a shadow of its MAX7219 register file. The
//   displayed image is derived from that register file.
// Ports:
//   clk         system clock, at least 4x LED_CLK
//   reset_n     asynchronous active-low reset
//   link        serial link (slave modport: DIN, CS, LED_CLK)
//   rows        raw digit registers, rows[d*64 + r*8 +: 8] = device d, addr r+1
//   pixels      displayed image, same packing as rows
//   intensity   intensity register (addr 0xA), 4 bits per device
//   shutdown_n  1 = normal operation (addr 0xC bit 0), per device
//   upd         1-cycle pulse, device register file written this cycle
//   frame_err   1-cycle pulse, load seen with bit count != 16*N_DEV
module matrix_frame_receiver #(
  parameter int N_DEV = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  matrix_frame_receiver_if.slave link,
  output logic [N_DEV*64-1:0]   rows,
  output logic [N_DEV*64-1:0]   pixels,
  output logic [N_DEV*4-1:0]    intensity,
  output logic [N_DEV-1:0]      shutdown_n,
  output logic [N_DEV-1:0]      upd,
  output logic                  frame_err
);

  localparam int NBITS = 16 * N_DEV;
  localparam int CW    = $clog2(NBITS + 2);
  localparam logic [CW-1:0] CNT_MAX  = CW'(NBITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NBITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Displayed image of one device: test mode lights everything, shutdown
  // blanks everything, otherwise rows above the scan limit stay dark.
  function automatic logic [63:0] image(input logic [63:0] r,
                                        input logic [2:0]  lim,
                                        input logic        on,
                                        input logic        tst);
    logic [63:0] img;
    img = 64'h0;
    if (tst) begin
      img = {64{1'b1}};
    end else if (!on) begin
      img = 64'h0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (3'(i) <= lim) begin
          img[8*i +: 8] = r[8*i +: 8];
        end else begin
          img[8*i +: 8] = 8'h00;
        end
      end
    end
    return img;
  endfunction

  logic din_m, din_s, cs_m, cs_s, lclk_m, lclk_s;
  logic cs_d, lclk_d;
  logic cs_rise, cs_fall, clk_rise;

  state_t state, state_nxt;
  logic   do_shift;

  logic [NBITS-1:0] sr;
  logic [CW-1:0]    bit_cnt;

  logic [N_DEV*8-1:0]  decode_mode;
  logic [N_DEV*3-1:0]  scan_limit;
  logic [N_DEV-1:0]    disp_test;

  logic [N_DEV*64-1:0] rows_nxt, pix_nxt;
  logic [N_DEV*8-1:0]  mode_nxt;
  logic [N_DEV*4-1:0]  int_nxt;
  logic [N_DEV*3-1:0]  lim_nxt;
  logic [N_DEV-1:0]    sd_nxt, tst_nxt, upd_nxt;
  logic                err_nxt;
  logic [3:0]          addr;
  logic [7:0]          data;
  logic [2:0]          ridx;

  // decode_mode is held as a register but never decoded (no BCD font here);
  // the top word nibble is a don't-care in the MAX7219 format.
  logic unused_bits;
  assign unused_bits = ^{decode_mode, sr[NBITS-1]};

  // Two-flop synchronizers plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_m  <= 1'b0;
      din_s  <= 1'b0;
      cs_m   <= 1'b1;
      cs_s   <= 1'b1;
      lclk_m <= 1'b0;
      lclk_s <= 1'b0;
      cs_d   <= 1'b1;
      lclk_d <= 1'b0;
    end else begin
      din_m  <= link.DIN;
      din_s  <= din_m;
      cs_m   <= link.CS;
      cs_s   <= cs_m;
      lclk_m <= link.LED_CLK;
      lclk_s <= lclk_m;
      cs_d   <= cs_s;
      lclk_d <= lclk_s;
    end
  end

  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign clk_rise = lclk_s & ~lclk_d;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; a load edge takes priority over a coincident clock edge.
  always_comb begin
    state_nxt = state;
    do_shift  = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nxt = LATCH;
        end else if (clk_rise) begin
          do_shift = 1'b1;
        end else begin
          state_nxt = SHIFT;
        end
      end
      LATCH: begin
        // A new frame may start while the previous one is being latched.
        if (cs_fall) begin
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and saturating bit counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr      <= {NBITS{1'b0}};
      bit_cnt <= {CW{1'b0}};
    end else begin
      if (cs_fall) begin
        bit_cnt <= {CW{1'b0}};
      end else if (do_shift && (bit_cnt != CNT_MAX)) begin
        bit_cnt <= bit_cnt + CW'(1);
      end
      if (do_shift) begin
        sr <= {sr[NBITS-2:0], din_s};
      end
    end
  end

  // Register-file decode during LATCH; device d only updates when its whole
  // word arrived (device 0 holds the last word shifted in).
  always_comb begin
    rows_nxt = rows;
    mode_nxt = decode_mode;
    int_nxt  = intensity;
    lim_nxt  = scan_limit;
    sd_nxt   = shutdown_n;
    tst_nxt  = disp_test;
    upd_nxt  = {N_DEV{1'b0}};
    err_nxt  = 1'b0;
    addr     = 4'h0;
    data     = 8'h00;
    ridx     = 3'd0;
    if (state == LATCH) begin
      err_nxt = (bit_cnt != CNT_FULL);
      for (int d = 0; d < N_DEV; d++) begin
        addr = sr[16*d + 8 +: 4];
        data = sr[16*d +: 8];
        ridx = 3'(addr - 4'd1);
        if (bit_cnt >= CW'(16 * (d + 1))) begin
          case (addr)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
              rows_nxt[64*d + 8*ridx +: 8] = data;
              upd_nxt[d] = 1'b1;
            end
            4'h9: begin
              mode_nxt[8*d +: 8] = data;
              upd_nxt[d] = 1'b1;
            end
            4'hA: begin
              int_nxt[4*d +: 4] = data[3:0];
              upd_nxt[d] = 1'b1;
            end
            4'hB: begin
              lim_nxt[3*d +: 3] = data[2:0];
              upd_nxt[d] = 1'b1;
            end
            4'hC: begin
              sd_nxt[d]  = data[0];
              upd_nxt[d] = 1'b1;
            end
            4'hF: begin
              tst_nxt[d] = data[0];
              upd_nxt[d] = 1'b1;
            end
            default: upd_nxt[d] = 1'b0;  // 0x0 no-op, 0xD/0xE unused
          endcase
        end else begin
          upd_nxt[d] = 1'b0;
        end
      end
    end else begin
      err_nxt = 1'b0;
    end
  end

  // Image built from the next register values so it lands with them.
  always_comb begin
    pix_nxt = {N_DEV*64{1'b0}};
    for (int d = 0; d < N_DEV; d++) begin
      pix_nxt[64*d +: 64] = image(rows_nxt[64*d +: 64], lim_nxt[3*d +: 3],
                                  sd_nxt[d], tst_nxt[d]);
    end
  end

  // Register file, image and status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rows        <= {N_DEV*64{1'b0}};
      pixels      <= {N_DEV*64{1'b0}};
      decode_mode <= {N_DEV*8{1'b0}};
      intensity   <= {N_DEV*4{1'b0}};
      scan_limit  <= {N_DEV*3{1'b0}};
      shutdown_n  <= {N_DEV{1'b0}};
      disp_test   <= {N_DEV{1'b0}};
      upd         <= {N_DEV{1'b0}};
      frame_err   <= 1'b0;
    end else begin
      rows        <= rows_nxt;
      pixels      <= pix_nxt;
      decode_mode <= mode_nxt;
      intensity   <= int_nxt;
      scan_limit  <= lim_nxt;
      shutdown_n  <= sd_nxt;
      disp_test   <= tst_nxt;
      upd         <= upd_nxt;
      frame_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_matrix_frame_receiver.sv
// tb_matrix_frame_receiver
//   Drives one N_DEV=1 and one N_DEV=2 receiver through directed link
//   transactions. Expected results are queued when a load is driven and
//   compared when the receiver pulses upd/frame_err.
module tb_matrix_frame_receiver;

  typedef struct packed {
    logic [1:0]   upd;
    logic         ferr;
    logic [127:0] rows;
    logic [127:0] pix;
    logic [7:0]   inten;
    logic [1:0]   sd;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  matrix_frame_receiver_if link1 ();
  matrix_frame_receiver_if link2 ();

  logic [63:0]  rows1, pixels1;
  logic [3:0]   intensity1;
  logic [0:0]   shutdown_n1, upd1;
  logic         frame_err1;
  logic [127:0] rows2, pixels2;
  logic [7:0]   intensity2;
  logic [1:0]   shutdown_n2, upd2;
  logic         frame_err2;

  matrix_frame_receiver #(.N_DEV(1)) u1 (
    .clk(clk), .reset_n(reset_n), .link(link1),
    .rows(rows1), .pixels(pixels1), .intensity(intensity1),
    .shutdown_n(shutdown_n1), .upd(upd1), .frame_err(frame_err1)
  );

  matrix_frame_receiver #(.N_DEV(2)) u2 (
    .clk(clk), .reset_n(reset_n), .link(link2),
    .rows(rows2), .pixels(pixels2), .intensity(intensity2),
    .shutdown_n(shutdown_n2), .upd(upd2), .frame_err(frame_err2)
  );

  int vectors = 0;
  int miscompares = 0;
  int n_upd1 = 0, n_err1 = 0, n_upd2 = 0, n_err2 = 0;

  exp_t  sb[$];
  string tagq[$];

  // Model of the single-device receiver's register file.
  logic [63:0] m_rows;
  logic [2:0]  m_lim;
  logic        m_sd, m_tst;
  logic [3:0]  m_int;

  // Pulse counters over the whole run.
  always @(negedge clk) begin
    if (upd1 != 1'b0) n_upd1 <= n_upd1 + 1;
    if (frame_err1)   n_err1 <= n_err1 + 1;
    if (upd2 != 2'b00) n_upd2 <= n_upd2 + 1;
    if (frame_err2)   n_err2 <= n_err2 + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int sel, input logic din, input logic cs, input logic lclk);
    if (sel == 1) begin
      link1.DIN = din; link1.CS = cs; link1.LED_CLK = lclk;
    end else begin
      link2.DIN = din; link2.CS = cs; link2.LED_CLK = lclk;
    end
  endtask

  // CS low, n bits MSB first, leaves CS low and LED_CLK low.
  task automatic shift_bits(input int sel, input logic [63:0] bits, input int n);
    drive(sel, 1'b0, 1'b0, 1'b0);
    wait_clks(4);
    for (int i = n - 1; i >= 0; i--) begin
      drive(sel, bits[i], 1'b0, 1'b0);
      wait_clks(4);
      drive(sel, bits[i], 1'b0, 1'b1);
      wait_clks(4);
    end
    drive(sel, 1'b0, 1'b0, 1'b0);
    wait_clks(4);
  endtask

  function automatic logic [63:0] m_pix();
    logic [63:0] p;
    p = 64'h0;
    if (m_tst) p = {64{1'b1}};
    else if (m_sd) begin
      for (int r = 0; r < 8; r++)
        if (r <= int'(m_lim)) p[8*r +: 8] = m_rows[8*r +: 8];
    end
    return p;
  endfunction

  task automatic model_reset();
    m_rows = 64'h0; m_lim = 3'd0; m_sd = 1'b0; m_tst = 1'b0; m_int = 4'h0;
  endtask

  task automatic model_word(input logic [15:0] w, output logic u);
    int a;
    a = int'(w[11:8]);
    u = 1'b1;
    if (a >= 1 && a <= 8) m_rows[8*(a-1) +: 8] = w[7:0];
    else if (a == 9)  u = 1'b1;
    else if (a == 10) m_int = w[3:0];
    else if (a == 11) m_lim = w[2:0];
    else if (a == 12) m_sd = w[0];
    else if (a == 15) m_tst = w[0];
    else u = 1'b0;
  endtask

  task automatic push1(input string tag, input logic u, input logic ferr);
    exp_t e;
    e.upd = {1'b0, u}; e.ferr = ferr;
    e.rows = {64'h0, m_rows}; e.pix = {64'h0, m_pix()};
    e.inten = {4'h0, m_int}; e.sd = {1'b0, m_sd};
    sb.push_back(e); tagq.push_back(tag);
  endtask

  function automatic bit pulse(input int sel);
    if (sel == 1) return (upd1 != 1'b0) || frame_err1;
    return (upd2 != 2'b00) || frame_err2;
  endfunction

  // Waits for the output pulse after a load, then pops and compares.
  task automatic wait_result(input int sel);
    exp_t e;
    string tag;
    int lat;
    logic [127:0] o_upd, o_err, o_rows, o_pix, o_int, o_sd;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (pulse(sel)) begin
        lat = k;
        break;
      end
    end
    e = sb.pop_front();
    tag = tagq.pop_front();
    if (lat == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: no upd/frame_err pulse within 20 clocks", tag);
    end else begin
      if (sel == 1) begin
        o_upd = 128'(upd1); o_err = 128'(frame_err1); o_rows = 128'(rows1);
        o_pix = 128'(pixels1); o_int = 128'(intensity1); o_sd = 128'(shutdown_n1);
      end else begin
        o_upd = 128'(upd2); o_err = 128'(frame_err2); o_rows = rows2;
        o_pix = pixels2; o_int = 128'(intensity2); o_sd = 128'(shutdown_n2);
      end
      check({tag, "/latency"}, 128'(lat), 128'(4));
      check({tag, "/upd"}, o_upd, 128'(e.upd));
      check({tag, "/frame_err"}, o_err, 128'(e.ferr));
      check({tag, "/rows"}, o_rows, e.rows);
      check({tag, "/pixels"}, o_pix, e.pix);
      check({tag, "/intensity"}, o_int, 128'(e.inten));
      check({tag, "/shutdown_n"}, o_sd, 128'(e.sd));
      @(negedge clk);
      check({tag, "/pulse_width"}, 128'(pulse(sel)), 128'(0));
    end
    wait_clks(2);
  endtask

  task automatic send1(input string tag, input logic [15:0] w);
    logic u;
    model_word(w, u);
    push1(tag, u, 1'b0);
    shift_bits(1, {48'h0, w}, 16);
    drive(1, 1'b0, 1'b1, 1'b0);
    wait_result(1);
  endtask

  initial begin
    int snap_u, snap_e;
    exp_t e2;
    logic u;

    drive(1, 1'b0, 1'b1, 1'b0);
    drive(2, 1'b0, 1'b1, 1'b0);
    model_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    wait_clks(3);
    reset_n = 1'b1;
    wait_clks(10);

    // Reset state with an idle link.
    check("rst/rows1", 128'(rows1), 128'(0));
    check("rst/pixels1", 128'(pixels1), 128'(0));
    check("rst/shutdown_n1", 128'(shutdown_n1), 128'(0));
    check("rst/intensity1", 128'(intensity1), 128'(0));
    check("rst/rows2", rows2, 128'(0));
    check("rst/pulses", 128'(n_upd1 + n_err1 + n_upd2 + n_err2), 128'(0));

    // Basic word sequence on the single-device receiver.
    snap_u = n_upd1;
    send1("w0C01", 16'h0C01);
    send1("w0B07", 16'h0B07);
    send1("w03A5", 16'h03A5);
    check("seq/upd_count", 128'(n_upd1 - snap_u), 128'(3));

    // Short load: frame error, nothing written.
    snap_u = n_upd1;
    push1("short12", 1'b0, 1'b1);
    shift_bits(1, 64'hC00, 12);
    drive(1, 1'b0, 1'b1, 1'b0);
    wait_result(1);
    check("short12/no_upd", 128'(n_upd1 - snap_u), 128'(0));

    // Scan limit, full rows, display test on and off.
    send1("w0B02", 16'h0B02);
    for (int r = 1; r <= 8; r++) send1("rowFF", {8'(r), 8'hFF});
    send1("w0F01", 16'h0F01);
    send1("w0F00", 16'h0F00);

    // Load edge coincident with a clock edge: the extra bit is dropped.
    model_word(16'h0211, u);
    push1("coincident", u, 1'b0);
    shift_bits(1, 64'h0211, 16);
    drive(1, 1'b1, 1'b1, 1'b1);
    wait_result(1);
    drive(1, 1'b0, 1'b1, 1'b0);
    wait_clks(4);
    check("idle2/no_pulses", 128'(n_upd2 + n_err2), 128'(0));

    // Two-device chain, one 32-bit load.
    e2.upd = 2'b11; e2.ferr = 1'b0; e2.rows = 128'h0; e2.pix = 128'h0;
    e2.inten = 8'h3C; e2.sd = 2'b00;
    sb.push_back(e2); tagq.push_back("chain32");
    shift_bits(2, 64'h0A03_0A0C, 32);
    drive(2, 1'b0, 1'b1, 1'b0);
    wait_result(2);

    // Reset in the middle of a word.
    snap_u = n_upd1;
    snap_e = n_err1;
    shift_bits(1, 64'h1FF, 9);
    reset_n = 1'b0;
    wait_clks(3);
    drive(1, 1'b0, 1'b1, 1'b0);
    wait_clks(2);
    reset_n = 1'b1;
    model_reset();
    wait_clks(10);
    check("midrst/rows1", 128'(rows1), 128'(0));
    check("midrst/pixels1", 128'(pixels1), 128'(0));
    check("midrst/shutdown_n1", 128'(shutdown_n1), 128'(0));
    check("midrst/no_pulses", 128'((n_upd1 - snap_u) + (n_err1 - snap_e)), 128'(0));
    snap_u = n_upd1;
    send1("w0155", 16'h0155);
    check("midrst/upd_count", 128'(n_upd1 - snap_u), 128'(1));
    check("midrst/err_count", 128'(n_err1 - snap_e), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
